// File: rtl/fxp32_dot_seq_pkg.sv
// Shared definitions for the fxp32 dot-product sequencer.
//   FXP32_WIDTH : data path width of the Q16.16 operands and result
//   dotseq_st_e : sequencer FSM state encoding (3 bits)
package fxp32_dot_seq_pkg;

  localparam int unsigned FXP32_WIDTH = 32;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StFeed  = 3'd1,
    StDrain = 3'd2,
    StDone  = 3'd3,
    StErr   = 3'd4
  } dotseq_st_e;

endpackage

// File: rtl/fxp32_dot_seq_cnt.sv
// Loadable down-counter with a zero flag.
//   clk, rstn  : clock, asynchronous active-low reset
//   i_load     : load i_load_val (takes priority over i_dec)
//   i_load_val : value to load
//   i_dec      : decrement by one; holds at zero
//   o_cnt      : current count
//   o_zero     : count equals zero
module fxp32_dot_seq_cnt
  import fxp32_dot_seq_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic [W-1:0] o_cnt,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_cnt  = r_cnt;
  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/fxp32_dot_seq.sv
// Sequencer that drives one fxp32_mac to compute a dot product of len pairs.
//   clk, rstn            : clock, asynchronous active-low reset
//   start, len, busy     : job command (sampled in IDLE only) and busy status
//   in_valid/in_ready    : operand pair stream (in_a, in_b)
//   out_valid/out_ready  : registered result (out_c)
//   err                  : sticky stall-timeout flag
//   mac_*                : MAC control/data; mac_out is the MAC accumulator output
// Optional feature: define FXP32_DOT_SEQ_TIMEOUT_EN to abort a job after TO_CYC
// consecutive FEED cycles without in_valid; otherwise err is tied 0.
module fxp32_dot_seq
  import fxp32_dot_seq_pkg::*;
#(
  parameter int unsigned MAC_LAT = 7,
  parameter int unsigned LEN_W   = 16,
  parameter int unsigned TO_CYC  = 255
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   start,
  input  logic [LEN_W-1:0]       len,
  output logic                   busy,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [FXP32_WIDTH-1:0] in_a,
  input  logic [FXP32_WIDTH-1:0] in_b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [FXP32_WIDTH-1:0] out_c,
  output logic                   err,
  output logic                   mac_rstn,
  output logic                   mac_acc,
  output logic                   mac_prstn,
  output logic [FXP32_WIDTH-1:0] mac_a,
  output logic [FXP32_WIDTH-1:0] mac_b,
  input  logic [FXP32_WIDTH-1:0] mac_out
);

  localparam int unsigned DCNT_W = $clog2(MAC_LAT) + 1;

  dotseq_st_e             r_state, w_state_next;
  logic                   w_xfer, w_last, w_stall_hit;
  logic [LEN_W-1:0]       w_cnt;
  logic                   w_cnt_zero;
  logic [DCNT_W-1:0]      w_dcnt_unused;
  logic                   w_dcnt_zero;
  logic [FXP32_WIDTH-1:0] r_out_c;
  logic                   r_out_valid;
  logic                   r_err;

  assign w_xfer = in_valid && in_ready;
  assign w_last = (w_cnt == LEN_W'(1));

  // Remaining pairs of the current job.
  fxp32_dot_seq_cnt #(.W(LEN_W)) u_cnt (
    .clk        (clk),
    .rstn       (rstn),
    .i_load     ((r_state == StIdle) && start && (len != '0)),
    .i_load_val (len),
    .i_dec      (w_xfer),
    .o_cnt      (w_cnt),
    .o_zero     (w_cnt_zero)
  );

  // Drain wait: the capture cycle lines up with the last pair's MAC latency.
  fxp32_dot_seq_cnt #(.W(DCNT_W)) u_dcnt (
    .clk        (clk),
    .rstn       (rstn),
    .i_load     ((r_state == StFeed) && w_xfer && w_last),
    .i_load_val (DCNT_W'(MAC_LAT - 1)),
    .i_dec      (r_state == StDrain),
    .o_cnt      (w_dcnt_unused),
    .o_zero     (w_dcnt_zero)
  );

`ifdef FXP32_DOT_SEQ_TIMEOUT_EN
  localparam int unsigned SCNT_W = $clog2(TO_CYC + 1);
  logic [SCNT_W-1:0] r_scnt;

  assign w_stall_hit = (r_scnt == SCNT_W'(TO_CYC));

  // Consecutive FEED cycles without in_valid.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_scnt <= '0;
    end else if ((r_state == StFeed) && !in_valid && !w_stall_hit) begin
      r_scnt <= r_scnt + SCNT_W'(1);
    end else begin
      r_scnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_err <= 1'b0;
    end else if ((r_state == StFeed) && w_stall_hit) begin
      r_err <= 1'b1;
    end else if ((r_state == StErr) && start) begin
      r_err <= 1'b0;
    end
  end
`else
  logic w_unused_to;
  assign w_unused_to = (TO_CYC == 0);
  assign w_stall_hit = 1'b0;
  assign r_err       = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (start) w_state_next = (len == '0) ? StDone : StFeed;
      end
      StFeed: begin
        if (w_stall_hit)          w_state_next = StErr;
        else if (w_xfer && w_last) w_state_next = StDrain;
      end
      StDrain: begin
        if (w_dcnt_zero) w_state_next = StDone;
      end
      StDone: begin
        if (out_ready) w_state_next = StIdle;
      end
      StErr: begin
        if (start) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  // Outputs decoded from state.
  always_comb begin
    busy      = (r_state != StIdle);
    // cnt is never zero in FEED; the guard keeps a stray transfer impossible.
    in_ready  = (r_state == StFeed) && !w_cnt_zero && !w_stall_hit;
    mac_rstn  = (r_state == StFeed) || (r_state == StDrain);
    mac_acc   = mac_rstn;
    mac_prstn = 1'b1;
    mac_a     = w_xfer ? in_a : '0;
    mac_b     = w_xfer ? in_b : '0;
  end

  // Result register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_out_c     <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (start && (len == '0)) begin
            r_out_c     <= '0;
            r_out_valid <= 1'b1;
          end
        end
        StDrain: begin
          if (w_dcnt_zero) begin
            r_out_c     <= mac_out;
            r_out_valid <= 1'b1;
          end
        end
        StDone: begin
          if (out_ready) r_out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign out_c     = r_out_c;
  assign out_valid = r_out_valid;
  assign err       = r_err;

endmodule

// File: tb/tb_fxp32_dot_seq.sv
// Self-checking bench for fxp32_dot_seq with a behavioural Q16.16 MAC attached.
module tb_fxp32_dot_seq;
  localparam int unsigned MAC_LAT = 7;
  localparam int unsigned LEN_W   = 16;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             start = 1'b0;
  logic [LEN_W-1:0] len = '0;
  logic             busy, in_ready, out_valid, err;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b0;
  logic [31:0]      in_a = '0, in_b = '0, out_c;
  logic             mac_rstn, mac_acc, mac_prstn;
  logic [31:0]      mac_a, mac_b, mac_out;

  int checks = 0;
  int errors = 0;
  logic [31:0] op_a [16];
  logic [31:0] op_b [16];

  always #5 clk = ~clk;

  fxp32_dot_seq #(.MAC_LAT(MAC_LAT), .LEN_W(LEN_W), .TO_CYC(255)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .len       (len),
    .busy      (busy),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_c     (out_c),
    .err       (err),
    .mac_rstn  (mac_rstn),
    .mac_acc   (mac_acc),
    .mac_prstn (mac_prstn),
    .mac_a     (mac_a),
    .mac_b     (mac_b),
    .mac_out   (mac_out)
  );

  // Q16.16 product, truncated toward -inf.
  function automatic logic [31:0] qmul(input logic [31:0] a, input logic [31:0] b);
    longint pa, pb, p;
    pa = longint'($signed(a));
    pb = longint'($signed(b));
    p  = pa * pb;
    return 32'(p >>> 16);
  endfunction

  // Behavioural MAC: a pair's product lands in the accumulator MAC_LAT cycles later.
  logic [31:0] mac_pipe [MAC_LAT-1];
  logic [31:0] mac_acc_q;
  always_ff @(posedge clk) begin
    if (!mac_rstn || !mac_prstn) begin
      for (int i = 0; i < int'(MAC_LAT) - 1; i++) mac_pipe[i] <= '0;
      mac_acc_q <= '0;
    end else begin
      mac_pipe[0] <= qmul(mac_a, mac_b);
      for (int i = 1; i < int'(MAC_LAT) - 1; i++) mac_pipe[i] <= mac_pipe[i-1];
      mac_acc_q <= (mac_acc ? mac_acc_q : 32'h0) + mac_pipe[MAC_LAT-2];
    end
  end
  assign mac_out = mac_acc_q;

  function automatic logic [31:0] ref_dot(input int n);
    logic [31:0] s;
    s = '0;
    for (int i = 0; i < n; i++) s = s + qmul(op_a[i], op_b[i]);
    return s;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Start a job of n pairs, feed it with gaps (gap<0: random 0..3), wait for the result.
  task automatic feed_job(input int n, input int gap, input string tag);
    int k;
    start = 1'b1;
    len   = LEN_W'(n);
    step();
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      int g;
      g = (gap < 0) ? int'($urandom_range(0, 3)) : ((i == 0) ? 0 : gap);
      repeat (g) begin
        in_valid = 1'b0;
        in_a = $urandom;
        in_b = $urandom;
        #1;
        chk({tag, "_gap_mac_a"}, mac_a, 32'h0);
        step();
      end
      in_valid = 1'b1;
      in_a = op_a[i];
      in_b = op_b[i];
      #1;
      chk({tag, "_in_ready"}, {31'b0, in_ready}, 32'h1);
      step();
    end
    in_valid = 1'b0;
    k = 0;
    while (!out_valid && k < 40) begin
      step();
      k++;
    end
    chk({tag, "_latency"}, k, MAC_LAT);
    chk({tag, "_out_c"}, out_c, ref_dot(n));
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_valid_clr"}, {31'b0, out_valid}, 32'h0);
    chk({tag, "_idle"}, {31'b0, busy}, 32'h0);
  endtask

  initial begin
    repeat (2) step();
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_out_c", out_c, 32'h0);
    chk("rst_err", {31'b0, err}, 32'h0);
    chk("rst_mac_rstn", {31'b0, mac_rstn}, 32'h0);
    chk("rst_mac_acc", {31'b0, mac_acc}, 32'h0);
    chk("rst_mac_prstn", {31'b0, mac_prstn}, 32'h1);
    rstn = 1'b1;
    step();

    // 1: 1+2+3 = 6.0 with continuous valid.
    for (int i = 0; i < 3; i++) begin
      op_a[i] = 32'((i + 1) << 16);
      op_b[i] = 32'h0001_0000;
    end
    feed_job(3, 0, "t1");
    chk("t1_abs", out_c, 32'h0006_0000);
    consume("t1");

    // 2: same with 4-cycle gaps.
    feed_job(3, 4, "t2");
    chk("t2_abs", out_c, 32'h0006_0000);
    consume("t2");

    // 3: zero-length job.
    start = 1'b1;
    len   = '0;
    #1;
    chk("t3_in_ready0", {31'b0, in_ready}, 32'h0);
    step();
    start = 1'b0;
    chk("t3_valid", {31'b0, out_valid}, 32'h1);
    chk("t3_out_c", out_c, 32'h0);
    chk("t3_in_ready1", {31'b0, in_ready}, 32'h0);
    consume("t3");

    // 4: hold result under backpressure; start pulses ignored.
    op_a[0] = 32'h0003_8000;
    op_b[0] = 32'h0002_0000;
    op_a[1] = 32'hFFFF_0000;
    op_b[1] = 32'h0000_4000;
    feed_job(2, 1, "t4");
    for (int i = 0; i < 10; i++) begin
      start = i[0];
      len   = 16'd5;
      step();
      chk("t4_hold_valid", {31'b0, out_valid}, 32'h1);
      chk("t4_hold_c", out_c, 32'h0006_C000);
    end
    start = 1'b0;
    consume("t4");

    // 5: async reset mid-FEED, then a fresh job.
    start = 1'b1;
    len   = 16'd4;
    step();
    start = 1'b0;
    in_valid = 1'b1;
    in_a = 32'h0005_0000;
    in_b = 32'h0005_0000;
    repeat (2) step();
    in_valid = 1'b0;
    #2;
    rstn = 1'b0;
    #1;
    chk("t5_busy", {31'b0, busy}, 32'h0);
    chk("t5_out_valid", {31'b0, out_valid}, 32'h0);
    chk("t5_mac_rstn", {31'b0, mac_rstn}, 32'h0);
    step();
    rstn = 1'b1;
    step();
    op_a[0] = 32'h0002_0000;
    op_b[0] = 32'hFFFF_0000;
    feed_job(1, 0, "t5");
    chk("t5_abs", out_c, 32'hFFFE_0000);
    consume("t5");

    // Randomized jobs against the reference dot product.
    for (int j = 0; j < 6; j++) begin
      int n;
      n = int'($urandom_range(1, 8));
      for (int i = 0; i < n; i++) begin
        op_a[i] = $urandom_range(0, 32'h0010_0000) - 32'h0008_0000;
        op_b[i] = $urandom_range(0, 32'h0010_0000) - 32'h0008_0000;
      end
      feed_job(n, -1, "rnd");
      consume("rnd");
    end

`ifdef FXP32_DOT_SEQ_TIMEOUT_EN
    // 6: stall timeout.
    begin
      int k;
      start = 1'b1;
      len   = 16'd2;
      step();
      start = 1'b0;
      in_valid = 1'b1;
      in_a = 32'h0001_0000;
      in_b = 32'h0001_0000;
      step();
      in_valid = 1'b0;
      k = 0;
      while (!err && k < 400) begin
        step();
        k++;
      end
      chk("t6_err", {31'b0, err}, 32'h1);
      chk("t6_out_valid", {31'b0, out_valid}, 32'h0);
      chk("t6_mac_rstn", {31'b0, mac_rstn}, 32'h0);
      start = 1'b1;
      step();
      start = 1'b0;
      chk("t6_err_clr", {31'b0, err}, 32'h0);
      chk("t6_idle", {31'b0, busy}, 32'h0);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
